// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
//   Drains four show-ahead FIFOs into a single registered output stage using a
//   round-robin arbiter. One word per cycle is sustained while downstream is
//   ready. A free-running count of accepted words and per-source sticky
//   overflow flags are also kept.
//
//   Optional build macro: FIFO_DRAIN_URGENT_PRIO_EN
//     When defined, non-empty sources flagging AlmostFull are served ahead of
//     the others (round-robin among the urgent set). When undefined,
//     FifoAlmostFull is ignored.
//
// Ports
//   Clk            in   clock, rising edge
//   nReset         in   asynchronous active-low reset
//   Enable         in   1 = new pops allowed; a held word is still delivered
//   FifoEmpty      in   [3:0]  empty flag per source
//   FifoAlmostFull in   [3:0]  almost-full flag per source
//   FifoOverflow   in   [3:0]  overflow flag per source
//   FifoData       in   [63:0] head word of source i on [16i+15:16i]
//   ReadFIFO       out  [3:0]  one-hot pop strobe
//   OutData        out  [15:0] registered output word
//   OutSrc         out  [1:0]  source index of OutData
//   OutValid       out  OutData/OutSrc valid
//   OutReady       in   downstream accepts when OutValid & OutReady
//   WordCount      out  [15:0] accepted-word count, wraps
//   ErrFlag        out  [3:0]  sticky overflow flags
//   ClrErr         in   synchronous clear of ErrFlag (set wins)
module fifo_drain_arbiter (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Enable,
    input  logic [3:0]  FifoEmpty,
    input  logic [3:0]  FifoAlmostFull,
    input  logic [3:0]  FifoOverflow,
    input  logic [63:0] FifoData,
    output logic [3:0]  ReadFIFO,
    output logic [15:0] OutData,
    output logic [1:0]  OutSrc,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [15:0] WordCount,
    output logic [3:0]  ErrFlag,
    input  logic        ClrErr
);

    typedef enum logic [0:0] {
        StEmpty = 1'b0,
        StHold  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  src_q, src_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] count_q, count_d;
    logic [3:0]  err_q, err_d;

    logic [3:0]  cand;
    logic        grant_found;
    logic [1:0]  grant_idx;
    logic        load;
    logic        accept;

`ifdef FIFO_DRAIN_URGENT_PRIO_EN
    logic [3:0]  urgent;
`else
    logic        unused_almost_full;
    assign unused_almost_full = ^FifoAlmostFull;
`endif

    // Candidate set and round-robin search starting at ptr_q.
    always_comb begin
        cand = ~FifoEmpty;
`ifdef FIFO_DRAIN_URGENT_PRIO_EN
        urgent = ~FifoEmpty & FifoAlmostFull;
        if (|urgent) begin
            cand = urgent;
        end
`endif
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        // Walk from the farthest offset down so the nearest candidate wins.
        for (int i = 3; i >= 0; i--) begin
            if (cand[ptr_q + 2'(i)]) begin
                grant_found = 1'b1;
                grant_idx   = ptr_q + 2'(i);
            end
        end
    end

    assign accept = (state_q == StHold) & OutReady;
    // nReset gating keeps the pop strobe quiet while reset is asserted.
    assign load   = nReset & Enable & grant_found & ((state_q == StEmpty) | OutReady);

    always_comb begin
        ReadFIFO = 4'b0000;
        if (load) begin
            ReadFIFO = 4'b0001 << grant_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;

        if (load) begin
            state_d = StHold;
            data_d  = FifoData[{grant_idx, 4'b0000} +: 16];
            src_d   = grant_idx;
            ptr_d   = grant_idx + 2'd1;
        end else if (accept) begin
            state_d = StEmpty;
        end

        if (accept) begin
            count_d = count_q + 16'd1;
        end

        err_d = (ClrErr ? 4'b0000 : err_q) | FifoOverflow;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= StEmpty;
            data_q  <= 16'h0000;
            src_q   <= 2'b00;
            ptr_q   <= 2'b00;
            count_q <= 16'h0000;
            err_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign OutValid  = (state_q == StHold);
    assign OutData   = data_q;
    assign OutSrc    = src_q;
    assign WordCount = count_q;
    assign ErrFlag   = err_q;

endmodule

// File: doc/fifo_drain_arbiter.md
FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

Interface
REQ-001 The block SHALL serve exactly four FIFO sources (indices 0..3) and have no parameters; data width SHALL be fixed at 16 bits.
REQ-002 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 nReset  input  1  asynchronous, active-low reset.
REQ-004 Enable  input  1  1 = new pops allowed; 0 = no new pops, a word already held is still delivered.
REQ-005 FifoEmpty  input  4  Empty flag of source i on bit i.
REQ-006 FifoAlmostFull  input  4  AlmostFull flag of source i on bit i.
REQ-007 FifoOverflow  input  4  Overflow flag of source i on bit i.
REQ-008 FifoData  input  64  head word of source i on bits [16i+15:16i]; valid whenever FifoEmpty[i]=0 (show-ahead).
REQ-009 ReadFIFO  output  4  one-hot pop strobe, bit i drives ReadFIFO of source i.
REQ-010 OutData  output  16  registered word delivered downstream.
REQ-011 OutSrc  output  2  registered source index of OutData.
REQ-012 OutValid  output  1  OutData/OutSrc valid.
REQ-013 OutReady  input  1  downstream accepts word when OutValid=1 and OutReady=1.
REQ-014 WordCount  output  16  total words accepted downstream.
REQ-015 ErrFlag  output  4  sticky overflow flag per source.
REQ-016 ClrErr  input  1  synchronous clear of ErrFlag.

Function
REQ-017 States SHALL be EMPTY (OutValid=0) and HOLD (OutValid=1); no other states.
REQ-018 Load condition SHALL be Enable=1 and (state EMPTY, or state HOLD with OutReady=1) and at least one FifoEmpty bit = 0.
REQ-019 When load is true, ReadFIFO SHALL be combinationally asserted on exactly the granted bit g for that cycle; at the edge OutData<=FifoData[g], OutSrc<=g, OutValid<=1.
REQ-020 ReadFIFO SHALL be 4'b0000 whenever the load condition is false; never more than one bit high.
REQ-021 In HOLD with OutReady=1 and no load: OutValid SHALL go to 0 at the next edge (HOLD->EMPTY).
REQ-022 In HOLD with OutReady=0: OutData, OutSrc and OutValid SHALL hold unchanged, regardless of Enable.
REQ-023 Back-to-back throughput SHALL be one word per cycle while OutReady=1 and sources are non-empty.
REQ-024 Round-robin: 2-bit pointer Ptr; search order Ptr, Ptr+1, Ptr+2, Ptr+3 modulo 4; first non-empty source wins; after each grant Ptr<=g+1 (3 wraps to 0).
REQ-025 Latency: word popped in cycle N appears with OutValid=1 in cycle N+1.
REQ-026 WordCount SHALL increment by 1 on each OutValid&OutReady cycle, wrapping 16'hFFFF->16'h0000.
REQ-027 ErrFlag[i] SHALL set when FifoOverflow[i]=1; ClrErr=1 SHALL clear all bits; set wins over clear in the same cycle.

Reset
REQ-028 nReset low SHALL immediately force: state EMPTY, OutValid=0, OutData=16'h0000, OutSrc=2'b00, Ptr=2'b00, WordCount=16'h0000, ErrFlag=4'b0000.
REQ-029 While nReset is low, ReadFIFO SHALL be 4'b0000; a word held at reset SHALL be discarded.

Configuration
REQ-030 Macro FIFO_DRAIN_URGENT_PRIO_EN: when defined, if any source has FifoAlmostFull=1 and FifoEmpty=0, the grant SHALL be chosen only among those urgent sources using the REQ-024 search order and Ptr update.
REQ-031 Without FIFO_DRAIN_URGENT_PRIO_EN, FifoAlmostFull SHALL be ignored and arbitration SHALL be pure round-robin.

Verification
REQ-032 Reset, then source 2 alone holds 16'hA5A5, OutReady=1 -> ReadFIFO=4'b0100 in one cycle, next cycle OutData=16'hA5A5, OutSrc=2, OutValid=1, WordCount=1 after acceptance.
REQ-033 All four sources non-empty, OutReady=1 continuously -> grants 0,1,2,3,0 in consecutive cycles, one word per cycle.
REQ-034 OutValid=1 with OutReady=0 for 5 cycles -> ReadFIFO=0, OutData stable; OutReady=1 -> next pop same cycle.
REQ-035 With FIFO_DRAIN_URGENT_PRIO_EN, Ptr=0, sources 0 and 3 non-empty, FifoAlmostFull=4'b1000 -> grant 3; without the macro -> grant 0.
REQ-036 FifoOverflow[1] pulse -> ErrFlag=4'b0010 held; ClrErr=1 -> 4'b0000; nReset low mid-HOLD -> OutValid=0 immediately.
